// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared constants and helpers for the parameterised FIFO.
// Holds the default word width / address width and the depth and
// occupancy-counter width derived from them, plus a small encoding of the
// per-cycle operation actually performed by the FIFO.
// Optional feature macro used by this slice: FIFO_FWFT_EN
// (first-word-fall-through read port, see fifo_param.sv).

package fifo_pkg;

  // Default geometry: 16 words of 8 bits.
  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;

  // Derived geometry: number of words and width of an occupancy counter
  // that must be able to represent both 0 and a completely full FIFO.
  localparam int DEPTH_DEF   = 1 << ADDR_SIZE_DEF;
  localparam int COUNT_W_DEF = ADDR_SIZE_DEF + 1;

  // What the FIFO really does in a cycle once the push/pop requests have
  // been qualified against the full/empty state. Bit 0 is the accepted
  // push, bit 1 the accepted pop.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Fold the two accepted-request strobes into one operation code so the
  // occupancy update reads as a plain case statement.
  function automatic fifo_op_e op_of(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({pop_ok, push_ok});
  endfunction

endpackage

// File: rtl/ram_dp_param.sv
// ram_dp_param -- storage array for fifo_param.
// One synchronous write port and one asynchronous read port. The read port
// is combinational so that the FIFO controller decides when (and whether)
// the read word is captured; a write and a read to the same address in the
// same cycle return the old word, which is what the FIFO relies on when it
// pushes and pops simultaneously while full.

module ram_dp_param #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

  // Write port: the array carries no reset, only qualified writes land.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: combinational view of the addressed word.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param -- parameterised synchronous FIFO with programmable
// almost-full / almost-empty thresholds, hysteretic upstream pause and a
// sticky overflow/underflow error flag.
// Storage lives in ram_dp_param; this module owns the pointers, the
// occupancy count, the status flags and the read-data register.
// Optional feature macro: FIFO_FWFT_EN
//   undefined (default): a pop accepted in cycle N presents the word on
//                        data_out with data_valid=1 in cycle N+1 only.
//   defined:             first-word-fall-through; data_out shows the head
//                        word whenever the FIFO is non-empty and a pop
//                        consumes it at the clock edge.

module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   thr_af,
  input  logic [ADDR_SIZE:0]   thr_ae,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic                 fifo_error
);

  localparam int CW = ADDR_SIZE + 1;

  // Occupancy value of a completely full FIFO (2**ADDR_SIZE), built
  // without any width conversion.
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 push_drop;
  logic                 pop_ignore;
  logic [DATA_SIZE-1:0] ram_rd_data;
  fifo_op_e             op;

  // Status flags are decoded straight from the registered occupancy.
  assign data_count   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_COUNT);
  assign almost_full  = (count >= thr_af);
  assign almost_empty = (count <= thr_ae) && !fifo_empty;

  // A pop needs something to read; a push needs room, where a pop that is
  // accepted in the same cycle frees the slot the push will use. A pop on
  // an empty FIFO stays ignored even when a push arrives alongside it.
  assign pop_ok     = pop && !fifo_empty;
  assign push_ok    = push && (!fifo_full || pop_ok);
  assign push_drop  = push && !push_ok;
  assign pop_ignore = pop && !pop_ok;
  assign op         = op_of(push_ok, pop_ok);

  // Next occupancy: up on a lone push, down on a lone pop, otherwise hold.
  always_comb begin
    count_next = count;
    case (op)
      OP_PUSH: count_next = count + CW'(1);
      OP_POP:  count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers and occupancy; pointers wrap modulo the depth on their own
  // because they are exactly ADDR_SIZE bits wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      count <= count_next;
    end
  end

  // Upstream pause with hysteresis, judged on the occupancy the FIFO is
  // about to have: raise at or above thr_af, drop at or below thr_ae,
  // otherwise keep the previous decision. Raising wins if both hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_pause <= 1'b0;
    end else if (count_next >= thr_af) begin
      fifo_pause <= 1'b1;
    end else if (count_next <= thr_ae) begin
      fifo_pause <= 1'b0;
    end
  end

  // Sticky error: a dropped push or an ignored pop raises it, err_clr
  // lowers it, and a new fault in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_error <= 1'b0;
    end else if (push_drop || pop_ignore) begin
      fifo_error <= 1'b1;
    end else if (err_clr) begin
      fifo_error <= 1'b0;
    end
  end

  // Storage; a push presented during reset must not land in the array.
  ram_dp_param #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok && !reset),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

`ifdef FIFO_FWFT_EN
  // First-word-fall-through: the head word is visible whenever there is
  // one, and an empty FIFO shows zero rather than stale array contents.
  assign data_valid = !fifo_empty;
  assign data_out   = fifo_empty ? '0 : ram_rd_data;
`else
  // Standard read: capture the head word on an accepted pop and flag it
  // valid for exactly the following cycle; data_out holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= ram_rd_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param -- self-checking bench for fifo_param (default geometry,
// 16 x 8). A queue-based reference model predicts every output; directed
// sequences, a small vector table and a randomized phase drive the DUT.
// Build with FIFO_FWFT_EN defined to exercise the fall-through read port.

module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [4:0] thr_af;
  logic [4:0] thr_ae;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic [4:0] data_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_pause;
  logic       fifo_error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_pause;
  logic       m_error;
  logic       m_valid;
  logic [7:0] m_dout;

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       clr;
    int         exp_count;
    logic       exp_empty;
    logic       exp_error;
  } vec_t;

  vec_t vecs[10];

  fifo_param #(
    .DATA_SIZE (8),
    .ADDR_SIZE (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .thr_af       (thr_af),
    .thr_ae       (thr_ae),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_count   (data_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_pause   (fifo_pause),
    .fifo_error   (fifo_error)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},   int'(data_count),   n);
    check({tag, ".empty"},   int'(fifo_empty),   int'(n == 0));
    check({tag, ".full"},    int'(fifo_full),    int'(n == 16));
    check({tag, ".afull"},   int'(almost_full),  int'(n >= int'(thr_af)));
    check({tag, ".aempty"},  int'(almost_empty), int'(n <= int'(thr_ae) && n != 0));
    check({tag, ".pause"},   int'(fifo_pause),   int'(m_pause));
    check({tag, ".error"},   int'(fifo_error),   int'(m_error));
`ifdef FIFO_FWFT_EN
    check({tag, ".valid"},   int'(data_valid),   int'(n != 0));
    if (n != 0) begin
      check({tag, ".dout"},  int'(data_out),     int'(mq[0]));
    end
`else
    check({tag, ".valid"},   int'(data_valid),   int'(m_valid));
    check({tag, ".dout"},    int'(data_out),     int'(m_dout));
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, step
  // past the clock edge and compare everything.
  task automatic applyStimulus(input logic rst, input logic p, input logic [7:0] d,
                               input logic q, input logic clr, input string tag);
    logic       full_now;
    logic       empty_now;
    logic       pop_ok;
    logic       push_ok;
    logic [7:0] head;
    int         nxt;
    reset   = rst;
    push    = p;
    data_in = d;
    pop     = q;
    err_clr = clr;
    full_now  = (mq.size() == 16);
    empty_now = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_pause = 1'b0;
      m_error = 1'b0;
      m_valid = 1'b0;
      m_dout  = 8'h00;
    end else begin
      pop_ok  = q && !empty_now;
      push_ok = p && (!full_now || pop_ok);
      m_valid = 1'b0;
      if (pop_ok) begin
        head = mq.pop_front();
`ifndef FIFO_FWFT_EN
        m_dout  = head;
        m_valid = 1'b1;
`endif
      end
      if (push_ok) mq.push_back(d);
      nxt = mq.size();
      if (nxt >= int'(thr_af)) m_pause = 1'b1;
      else if (nxt <= int'(thr_ae)) m_pause = 1'b0;
      if ((p && !push_ok) || (q && !pop_ok)) m_error = 1'b1;
      else if (clr) m_error = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    thr_af  = 5'd12;
    thr_ae  = 5'd4;
    mq.delete();
    m_pause = 1'b0;
    m_error = 1'b0;
    m_valid = 1'b0;
    m_dout  = 8'h00;

    // Vector table: short hand-computed sequence from a fresh reset.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b1};

    // Reset state
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "reset");
    check("reset.count", int'(data_count), 0);
    check("reset.empty", int'(fifo_empty), 1);
    check("reset.valid", int'(data_valid), 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].clr, "vec");
      check($sformatf("vec%0d.count", i), int'(data_count), vecs[i].exp_count);
      check($sformatf("vec%0d.empty", i), int'(fifo_empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d.error", i), int'(fifo_error), int'(vecs[i].exp_error));
    end

    // Fill to full, then overflow
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "fill.rst");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, "fill");
    check("fill.count16", int'(data_count), 16);
    check("fill.full",    int'(fifo_full), 1);
    check("fill.noerr",   int'(fifo_error), 0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
    check("ovf.count", int'(data_count), 16);
    check("ovf.error", int'(fifo_error), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr");
    check("clr.error", int'(fifo_error), 0);

    // Drain order, then underflow
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      check($sformatf("drain%0d.head", i), int'(data_out), i);
      check($sformatf("drain%0d.hvalid", i), int'(data_valid), 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
`else
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
      check($sformatf("drain%0d.dout", i), int'(data_out), i);
      check($sformatf("drain%0d.valid", i), int'(data_valid), 1);
`endif
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "udf");
    check("udf.count", int'(data_count), 0);
    check("udf.error", int'(fifo_error), 1);
`ifndef FIFO_FWFT_EN
    check("udf.valid", int'(data_valid), 0);
    check("udf.hold",  int'(data_out), 15);
`endif

    // Push+pop on empty: push taken, pop ignored
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr2");
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "pp_empty");
    check("pp_empty.count", int'(data_count), 1);
    check("pp_empty.error", int'(fifo_error), 1);

    // Push+pop on full: count holds, no error
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ppf.rst");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "ppf.fill");
    applyStimulus(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, "pp_full");
    check("pp_full.count", int'(data_count), 16);
    check("pp_full.error", int'(fifo_error), 0);
`ifndef FIFO_FWFT_EN
    check("pp_full.dout", int'(data_out), 8'h80);
`endif

    // Pause hysteresis
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "pause.rst");
    thr_af = 5'd12;
    thr_ae = 5'd4;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, "pause.fill");
    check("pause.set", int'(fifo_pause), 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "pause.drain");
    check("pause.at5.count", int'(data_count), 5);
    check("pause.at5", int'(fifo_pause), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "pause.rel");
    check("pause.at4", int'(fifo_pause), 0);

    // Wrap: 40 push/pop pairs through the pointers
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "wrap.rst");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'hC0 ^ i), 1'b0, 1'b0, "wrap.push");
`ifdef FIFO_FWFT_EN
      check($sformatf("wrap%0d.head", i), int'(data_out), int'(8'(8'hC0 ^ i)));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wrap.pop");
`else
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wrap.pop");
      check($sformatf("wrap%0d.dout", i), int'(data_out), int'(8'(8'hC0 ^ i)));
`endif
    end

    // Reset mid-traffic with count=7 and error set
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "mid.udf");
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0, "mid.fill");
    check("mid.count7", int'(data_count), 7);
    check("mid.err1",   int'(fifo_error), 1);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, "mid.rst");
    check("mid.count0", int'(data_count), 0);
    check("mid.empty",  int'(fifo_empty), 1);
    check("mid.err0",   int'(fifo_error), 0);

`ifdef FIFO_FWFT_EN
    // Fall-through: word visible without a pop, gone after the pop
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, "fwft.push");
    check("fwft.dout",   int'(data_out), 8'h5A);
    check("fwft.valid",  int'(data_valid), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "fwft.idle");
    check("fwft.hold",   int'(data_out), 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "fwft.pop");
    check("fwft.gone",   int'(data_valid), 0);
`endif

    // Randomized traffic with alternating fill-heavy / drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic rp;
      logic rq;
      logic rc;
      logic rr;
      if ((i % 100) == 0) begin
        thr_af = 5'($urandom_range(0, 16));
        thr_ae = 5'($urandom_range(0, 16));
      end
      if (((i / 200) % 2) == 0) begin
        rp = ($urandom_range(0, 99) < 75);
        rq = ($urandom_range(0, 99) < 35);
      end else begin
        rp = ($urandom_range(0, 99) < 35);
        rq = ($urandom_range(0, 99) < 75);
      end
      rc = ($urandom_range(0, 99) < 10);
      rr = ($urandom_range(0, 999) < 5);
      applyStimulus(rr, rp, 8'($urandom), rq, rc, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_SIZE, default 4, SHALL set the depth to 2**ADDR_SIZE words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 push  input  1  SHALL be the write request for the data_in word.
REQ-006 data_in  input  DATA_SIZE  SHALL be the word to write.
REQ-007 pop  input  1  SHALL be the read request.
REQ-008 thr_af  input  ADDR_SIZE+1  SHALL be the almost-full / pause-set threshold.
REQ-009 thr_ae  input  ADDR_SIZE+1  SHALL be the almost-empty / pause-release threshold.
REQ-010 err_clr  input  1  SHALL clear the sticky error flag.
REQ-011 data_out  output  DATA_SIZE  SHALL be the read word.
REQ-012 data_valid  output  1  SHALL qualify data_out.
REQ-013 data_count  output  ADDR_SIZE+1  SHALL be the current occupancy, 0..2**ADDR_SIZE.
REQ-014 fifo_empty, fifo_full, almost_full, almost_empty  output  1 each  SHALL be the status flags.
REQ-015 fifo_pause  output  1  SHALL be the upstream backpressure request.
REQ-016 fifo_error  output  1  SHALL be the sticky overflow/underflow flag.

Function
REQ-017 Flags SHALL be combinational from registered data_count: empty = (count==0); full = (count==2**ADDR_SIZE); almost_full = (count>=thr_af); almost_empty = (count<=thr_ae && count!=0).
REQ-018 A push SHALL be accepted when not full, or when full with an accepted pop in the same cycle; otherwise the word SHALL be dropped.
REQ-019 A pop SHALL be accepted only when not empty; a pop while empty SHALL be ignored, even with a simultaneous push.
REQ-020 Write and read pointers SHALL be ADDR_SIZE bits wide and SHALL wrap naturally modulo the depth.
REQ-021 data_count SHALL increment on an accepted push alone, decrement on an accepted pop alone, and hold when both or neither are accepted.
REQ-022 In standard mode, an accepted pop in cycle N SHALL present the head word on data_out with data_valid=1 in cycle N+1 only; data_out SHALL hold its value otherwise.
REQ-023 fifo_pause SHALL be registered and SHALL set when the next count >= thr_af, clear when the next count <= thr_ae, and otherwise hold; set SHALL win if both conditions hold.
REQ-024 fifo_error SHALL set on a dropped push or an ignored pop, and SHALL clear on err_clr; set SHALL win over a simultaneous err_clr.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL zero both pointers, data_count, data_out, data_valid, fifo_pause and fifo_error, ignoring push and pop.
REQ-026 A reset asserted mid-traffic SHALL discard all stored words; fifo_empty SHALL read 1 from the next cycle.

Configuration
REQ-027 With FIFO_FWFT_EN defined, the block SHALL use first-word-fall-through: data_out SHALL show the head word with data_valid = !fifo_empty, an accepted pop SHALL consume it at that edge, and read latency SHALL be 0.
REQ-028 Without FIFO_FWFT_EN, the block SHALL behave as in REQ-022, and all other requirements SHALL be unchanged.

Structure
REQ-029 Package fifo_pkg SHALL hold the default DATA_SIZE and ADDR_SIZE constants and the derived depth/count-width constants.
REQ-030 Storage SHALL be a sub-module, ram_dp_param, with a synchronous write port and a read port; fifo_param SHALL own pointers, count and flags.

Verification
REQ-031 The bench SHALL cover fill to full: reset, then 16 pushes of 0x00..0x0F (ADDR_SIZE=4) -> count=16, fifo_full=1; a 17th push of 0xAA -> dropped, fifo_error=1.
REQ-032 The bench SHALL cover drain order: 16 pops -> data_out 0x00..0x0F in order, each one cycle after its pop; then a pop -> ignored, fifo_error=1, count stays 0.
REQ-033 The bench SHALL cover pause hysteresis: thr_af=12, thr_ae=4; 12 pushes -> fifo_pause=1; pops down to 5 -> pause still 1; one more pop to 4 -> pause=0.
REQ-034 The bench SHALL cover simultaneous ops: push+pop when full -> count stays 16, no error; push+pop when empty -> count=1, fifo_error=1.
REQ-035 The bench SHALL cover wrap and reset: 40 push/pop pairs -> data intact across pointer wrap; reset with count=7 -> count=0, fifo_empty=1, fifo_error=0 next cycle.
REQ-036 The bench SHALL cover FWFT, with FIFO_FWFT_EN defined: push 0x5A into empty -> next cycle data_out=0x5A, data_valid=1 with no pop; pop -> data_valid=0 the following cycle.
